// File: rtl/ysyx_25030093_sram_arbiter.sv
// Round-robin arbiter sharing one single-ported SRAM between the IFU (reads)
// and the LSU (reads and writes). One transaction owns the SRAM from grant
// until its response handshake; payloads pass straight through unregistered.
module ysyx_25030093_sram_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  // IFU AR/R
  input  logic              IFU_arvalid,
  input  logic [ADDR_W-1:0] IFU_araddr,
  output logic              IFU_arready,
  input  logic              IFU_rready,
  output logic              IFU_rvalid,
  output logic [DATA_W-1:0] IFU_rdata,
  // LSU AR/R
  input  logic              LSU_arvalid,
  input  logic [ADDR_W-1:0] LSU_araddr,
  output logic              LSU_arready,
  input  logic              LSU_rready,
  output logic              LSU_rvalid,
  output logic [DATA_W-1:0] LSU_rdata,
  // LSU AW/W/B
  input  logic              LSU_awvalid,
  input  logic [ADDR_W-1:0] LSU_awaddr,
  output logic              LSU_awready,
  input  logic              LSU_wvalid,
  input  logic [DATA_W-1:0] LSU_wdata,
  input  logic [2:0]        LSU_wstrb,
  output logic              LSU_wready,
  input  logic              LSU_bready,
  output logic              LSU_bvalid,
  // SRAM side
  output logic              SRAM_arvalid,
  output logic [ADDR_W-1:0] SRAM_araddr,
  input  logic              SRAM_arready,
  output logic              SRAM_rready,
  input  logic              SRAM_rvalid,
  input  logic [DATA_W-1:0] SRAM_rdata,
  output logic              SRAM_awvalid,
  output logic [ADDR_W-1:0] SRAM_awaddr,
  input  logic              SRAM_awready,
  output logic              SRAM_wvalid,
  output logic [DATA_W-1:0] SRAM_wdata,
  output logic [2:0]        SRAM_wstrb,
  input  logic              SRAM_wready,
  output logic              SRAM_bready,
  input  logic              SRAM_bvalid
);

  typedef enum logic [1:0] {IDLE, IFU_RD, LSU_RD, LSU_WR} state_t;

  state_t state;
  logic   last;   // last granted master: 0 = IFU, 1 = LSU

  logic req_ifu, req_lsu_w, req_lsu;
  assign req_ifu   = IFU_arvalid;
  assign req_lsu_w = LSU_awvalid & LSU_wvalid;
  assign req_lsu   = LSU_arvalid | req_lsu_w;

  // Grant/release FSM; on contention the master that did not win last time wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_ifu && (!req_lsu || last)) begin
            state <= IFU_RD;
            last  <= 1'b0;
          end else if (req_lsu) begin
            // a pending write beats a simultaneous LSU read
            state <= req_lsu_w ? LSU_WR : LSU_RD;
            last  <= 1'b1;
          end
        end
        IFU_RD: if (SRAM_rvalid && IFU_rready) state <= IDLE;
        LSU_RD: if (SRAM_rvalid && LSU_rready) state <= IDLE;
        LSU_WR: if (SRAM_bvalid && LSU_bready) state <= IDLE;
      endcase
    end
  end

  // Route the granted master's channels to the SRAM; everything else is held at 0
  always_comb begin
    SRAM_arvalid = 1'b0;
    SRAM_rready  = 1'b0;
    SRAM_awvalid = 1'b0;
    SRAM_wvalid  = 1'b0;
    SRAM_bready  = 1'b0;
    SRAM_araddr  = (state == LSU_RD) ? LSU_araddr : IFU_araddr;
    SRAM_awaddr  = LSU_awaddr;
    SRAM_wdata   = LSU_wdata;
    SRAM_wstrb   = LSU_wstrb;
    IFU_arready  = 1'b0;
    IFU_rvalid   = 1'b0;
    IFU_rdata    = '0;
    LSU_arready  = 1'b0;
    LSU_rvalid   = 1'b0;
    LSU_rdata    = '0;
    LSU_awready  = 1'b0;
    LSU_wready   = 1'b0;
    LSU_bvalid   = 1'b0;
    unique case (state)
      IDLE: ;  // stale SRAM responses are dropped here
      IFU_RD: begin
        SRAM_arvalid = IFU_arvalid;
        SRAM_rready  = IFU_rready;
        IFU_arready  = SRAM_arready;
        IFU_rvalid   = SRAM_rvalid;
        IFU_rdata    = SRAM_rdata;
      end
      LSU_RD: begin
        SRAM_arvalid = LSU_arvalid;
        SRAM_rready  = LSU_rready;
        LSU_arready  = SRAM_arready;
        LSU_rvalid   = SRAM_rvalid;
        LSU_rdata    = SRAM_rdata;
      end
      LSU_WR: begin
        SRAM_awvalid = LSU_awvalid;
        SRAM_wvalid  = LSU_wvalid;
        SRAM_bready  = LSU_bready;
        LSU_awready  = SRAM_awready;
        LSU_wready   = SRAM_wready;
        LSU_bvalid   = SRAM_bvalid;
      end
    endcase
  end

endmodule

// File: tb/tb_ysyx_25030093_sram_arbiter.sv
// Directed bench: behavioural SRAM slave, per-master scoreboards of expected
// read data, and cycle-exact latency checks for grant order and release.
module tb_ysyx_25030093_sram_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        IFU_arvalid, IFU_arready, IFU_rready, IFU_rvalid;
  logic [31:0] IFU_araddr, IFU_rdata;
  logic        LSU_arvalid, LSU_arready, LSU_rready, LSU_rvalid;
  logic [31:0] LSU_araddr, LSU_rdata;
  logic        LSU_awvalid, LSU_awready, LSU_wvalid, LSU_wready, LSU_bready, LSU_bvalid;
  logic [31:0] LSU_awaddr, LSU_wdata;
  logic [2:0]  LSU_wstrb;
  logic        SRAM_arvalid, SRAM_arready, SRAM_rready, SRAM_rvalid;
  logic [31:0] SRAM_araddr, SRAM_rdata, SRAM_awaddr, SRAM_wdata;
  logic        SRAM_awvalid, SRAM_awready, SRAM_wvalid, SRAM_wready, SRAM_bready, SRAM_bvalid;
  logic [2:0]  SRAM_wstrb;

  ysyx_25030093_sram_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .IFU_arvalid(IFU_arvalid), .IFU_araddr(IFU_araddr), .IFU_arready(IFU_arready),
    .IFU_rready(IFU_rready), .IFU_rvalid(IFU_rvalid), .IFU_rdata(IFU_rdata),
    .LSU_arvalid(LSU_arvalid), .LSU_araddr(LSU_araddr), .LSU_arready(LSU_arready),
    .LSU_rready(LSU_rready), .LSU_rvalid(LSU_rvalid), .LSU_rdata(LSU_rdata),
    .LSU_awvalid(LSU_awvalid), .LSU_awaddr(LSU_awaddr), .LSU_awready(LSU_awready),
    .LSU_wvalid(LSU_wvalid), .LSU_wdata(LSU_wdata), .LSU_wstrb(LSU_wstrb),
    .LSU_wready(LSU_wready), .LSU_bready(LSU_bready), .LSU_bvalid(LSU_bvalid),
    .SRAM_arvalid(SRAM_arvalid), .SRAM_araddr(SRAM_araddr), .SRAM_arready(SRAM_arready),
    .SRAM_rready(SRAM_rready), .SRAM_rvalid(SRAM_rvalid), .SRAM_rdata(SRAM_rdata),
    .SRAM_awvalid(SRAM_awvalid), .SRAM_awaddr(SRAM_awaddr), .SRAM_awready(SRAM_awready),
    .SRAM_wvalid(SRAM_wvalid), .SRAM_wdata(SRAM_wdata), .SRAM_wstrb(SRAM_wstrb),
    .SRAM_wready(SRAM_wready), .SRAM_bready(SRAM_bready), .SRAM_bvalid(SRAM_bvalid)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit quiet_lsu = 1'b0;
  bit quiet_ifu = 1'b0;
  bit stale_rv  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [2:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 3; i++) if (s[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  // Behavioural SRAM: one read and one write outstanding, response one cycle after accept
  logic        s_rv = 1'b0;
  logic        s_bv = 1'b0;
  logic [31:0] s_rd = '0;
  logic [31:0] mem [256];
  logic [255:0] wr_done = '0;

  assign SRAM_arready = !s_rv;
  assign SRAM_rvalid  = s_rv | stale_rv;
  assign SRAM_rdata   = s_rd;
  assign SRAM_awready = !s_bv;
  assign SRAM_wready  = !s_bv;
  assign SRAM_bvalid  = s_bv;

  always @(posedge clk) begin
    if (s_rv && SRAM_rready) s_rv <= 1'b0;
    else if (SRAM_arvalid && !s_rv) begin
      s_rv <= 1'b1;
      s_rd <= wr_done[SRAM_araddr[9:2]] ? mem[SRAM_araddr[9:2]] : init_word(SRAM_araddr);
    end
    if (s_bv && SRAM_bready) s_bv <= 1'b0;
    else if (SRAM_awvalid && SRAM_wvalid && !s_bv) begin
      s_bv <= 1'b1;
      mem[SRAM_awaddr[9:2]] <= merge(wr_done[SRAM_awaddr[9:2]] ? mem[SRAM_awaddr[9:2]]
                                     : init_word(SRAM_awaddr), SRAM_wdata, SRAM_wstrb);
      wr_done[SRAM_awaddr[9:2]] <= 1'b1;
    end
  end

  // Reference memory and scoreboards
  logic [31:0]  ref_mem [256];
  logic [255:0] ref_done = '0;
  logic [31:0]  exp_ifu[$];
  logic [31:0]  exp_lsu[$];

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_done[a[9:2]] ? ref_mem[a[9:2]] : init_word(a);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] hs_all();
    return {IFU_arready, IFU_rvalid, LSU_arready, LSU_rvalid, LSU_awready, LSU_wready,
            LSU_bvalid, SRAM_arvalid, SRAM_rready, SRAM_awvalid, SRAM_wvalid, SRAM_bready};
  endfunction

  task automatic set_ar(input bit lsu, input logic v, input logic [31:0] a);
    if (lsu) begin LSU_arvalid = v; LSU_araddr = a; end
    else     begin IFU_arvalid = v; IFU_araddr = a; end
  endtask

  task automatic set_rr(input bit lsu, input logic v);
    if (lsu) LSU_rready = v; else IFU_rready = v;
  endtask

  function automatic logic arrdy(input bit lsu);
    return lsu ? LSU_arready : IFU_arready;
  endfunction

  function automatic logic rv(input bit lsu);
    return lsu ? LSU_rvalid : IFU_rvalid;
  endfunction

  function automatic logic [31:0] rdat(input bit lsu);
    return lsu ? LSU_rdata : IFU_rdata;
  endfunction

  // Read transaction, started at a falling edge. hold = rvalid cycles with rready low.
  task automatic rd(input bit lsu, input logic [31:0] a, input int hold, output int lat);
    logic [31:0] e, q;
    int t0, n, h;
    bit got;
    h = hold;
    got = 1'b0;
    e = ref_rd(a);
    if (lsu) exp_lsu.push_back(e); else exp_ifu.push_back(e);
    set_ar(lsu, 1'b1, a);
    set_rr(lsu, hold == 0);
    t0 = cyc;
    n = 0;
    #1;
    while (!arrdy(lsu) && n < 60) begin @(negedge clk); #1; n++; end
    chk("ar_grant", 64'(arrdy(lsu)), 64'd1);
    chk("sram_arvalid", 64'(SRAM_arvalid), 64'd1);
    chk("sram_araddr", 64'(SRAM_araddr), 64'(a));
    @(negedge clk);
    set_ar(lsu, 1'b0, a);
    #1;
    chk("sram_arvalid_drop", 64'(SRAM_arvalid), 64'd0);
    n = 0;
    while (n < 60) begin
      if (rv(lsu)) begin
        if (h > 0) begin
          chk("rdata_hold", 64'(rdat(lsu)), 64'(e));
          h--;
        end else begin
          set_rr(lsu, 1'b1);
          got = 1'b1;
          break;
        end
      end
      @(negedge clk); #1; n++;
    end
    chk("r_seen", 64'(got), 64'd1);
    lat = cyc - t0;
    if (lsu) begin
      if (exp_lsu.size() > 0) q = exp_lsu.pop_front(); else q = 'x;
    end else begin
      if (exp_ifu.size() > 0) q = exp_ifu.pop_front(); else q = 'x;
    end
    if (got) chk(lsu ? "lsu_rdata" : "ifu_rdata", 64'(rdat(lsu)), 64'(q));
    @(negedge clk);
    set_rr(lsu, 1'b0);
  endtask

  // LSU write transaction, started at a falling edge
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [2:0] s,
                    output int lat);
    int t0, n;
    ref_mem[a[9:2]] = merge(ref_rd(a), d, s);
    ref_done[a[9:2]] = 1'b1;
    LSU_awaddr = a; LSU_wdata = d; LSU_wstrb = s;
    LSU_awvalid = 1'b1; LSU_wvalid = 1'b1; LSU_bready = 1'b1;
    t0 = cyc;
    n = 0;
    #1;
    while (!LSU_awready && n < 60) begin @(negedge clk); #1; n++; end
    chk("aw_grant", 64'({LSU_awready, LSU_wready}), 64'd3);
    chk("sram_awwvalid", 64'({SRAM_awvalid, SRAM_wvalid}), 64'd3);
    chk("sram_awaddr", 64'(SRAM_awaddr), 64'(a));
    chk("sram_wdata", 64'(SRAM_wdata), 64'(d));
    chk("sram_wstrb", 64'(SRAM_wstrb), 64'(s));
    chk("no_rvalid_in_wr", 64'(LSU_rvalid), 64'd0);
    @(negedge clk);
    LSU_awvalid = 1'b0; LSU_wvalid = 1'b0;
    n = 0;
    #1;
    while (!LSU_bvalid && n < 60) begin
      chk("no_rvalid_in_wr", 64'(LSU_rvalid), 64'd0);
      @(negedge clk); #1; n++;
    end
    chk("b_seen", 64'(LSU_bvalid), 64'd1);
    chk("no_rvalid_at_b", 64'(LSU_rvalid), 64'd0);
    lat = cyc - t0;
    @(negedge clk);
    LSU_bready = 1'b0;
  endtask

  // Per-cycle invariants and quiet-master checks
  always @(negedge clk) begin
    #1;
    chk("resp_excl", 64'(IFU_rvalid & (LSU_rvalid | LSU_bvalid)), 64'd0);
    if (quiet_lsu)
      chk("lsu_quiet", 64'({LSU_arready, LSU_rvalid, LSU_awready, LSU_wready, LSU_bvalid})
          | 64'(LSU_rdata), 64'd0);
    if (quiet_ifu)
      chk("ifu_quiet", 64'({IFU_arready, IFU_rvalid}) | 64'(IFU_rdata), 64'd0);
  end

  initial begin
    #100000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    int l, l0, l1, a0, a1, b0, b1;
    IFU_arvalid = 0; IFU_araddr = '0; IFU_rready = 0;
    LSU_arvalid = 0; LSU_araddr = '0; LSU_rready = 0;
    LSU_awvalid = 0; LSU_awaddr = '0; LSU_wvalid = 0; LSU_wdata = '0; LSU_wstrb = '0;
    LSU_bready = 0;
    rst_n = 1'b0;
    #3;
    chk("rst_hs", 64'(hs_all()), 64'd0);
    chk("rst_rdata", 64'({IFU_rdata, LSU_rdata}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("idle_hs", 64'(hs_all()), 64'd0);
    @(negedge clk);

    // IFU read alone
    quiet_lsu = 1'b1;
    rd(1'b0, 32'h8000_0000, 0, l);
    quiet_lsu = 1'b0;
    chk("ifu_alone_lat", 64'(l), 64'd2);

    // LSU write alone, then read it back
    quiet_ifu = 1'b1;
    wr(32'h8000_0100, 32'hDEAD_BEEF, 3'b011, l);
    chk("wr_lat", 64'(l), 64'd2);
    rd(1'b1, 32'h8000_0100, 0, l);
    chk("wr_rdback_lat", 64'(l), 64'd2);
    quiet_ifu = 1'b0;

    // Contention from reset: IFU first, LSU data in cycle 5
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    fork
      rd(1'b0, 32'h8000_0020, 0, l0);
      rd(1'b1, 32'h8000_0040, 0, l1);
    join
    chk("cont_ifu_lat", 64'(l0), 64'd2);
    chk("cont_lsu_lat", 64'(l1), 64'd5);

    // Sustained contention alternates
    fork
      begin rd(1'b0, 32'h8000_0024, 0, a0); rd(1'b0, 32'h8000_0028, 0, a1); end
      begin rd(1'b1, 32'h8000_0044, 0, b0); rd(1'b1, 32'h8000_0048, 0, b1); end
    join
    chk("alt_ifu0", 64'(a0), 64'd2);
    chk("alt_lsu0", 64'(b0), 64'd5);
    chk("alt_ifu1", 64'(a1), 64'd5);
    chk("alt_lsu1", 64'(b1), 64'd5);

    // Simultaneous LSU read and write: write first, read on next grant
    fork
      wr(32'h8000_0200, 32'h1234_5678, 3'b111, l0);
      rd(1'b1, 32'h8000_0300, 0, l1);
    join
    chk("rw_wr_lat", 64'(l0), 64'd2);
    chk("rw_rd_lat", 64'(l1), 64'd5);
    rd(1'b1, 32'h8000_0200, 0, l);
    chk("rw_rdback_lat", 64'(l), 64'd2);

    // Backpressure on IFU; LSU waits
    fork
      rd(1'b0, 32'h8000_0080, 4, l0);
      rd(1'b1, 32'h8000_0090, 0, l1);
    join
    chk("bp_ifu_lat", 64'(l0), 64'd6);
    chk("bp_lsu_lat", 64'(l1), 64'd9);

    // Reset in the middle of an LSU read, then a stale rvalid in IDLE
    LSU_araddr = 32'h8000_00A0; LSU_arvalid = 1'b1; LSU_rready = 1'b1;
    @(negedge clk);
    #1;
    chk("abort_pre", 64'({SRAM_arvalid, LSU_arready}), 64'd3);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_hs", 64'(hs_all()), 64'd0);
    chk("abort_rdata", 64'({IFU_rdata, LSU_rdata}), 64'd0);
    LSU_arvalid = 1'b0; LSU_rready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    stale_rv = 1'b1;
    IFU_rready = 1'b1;
    LSU_rready = 1'b1;
    repeat (2) begin
      #1;
      chk("stale_drop", 64'({IFU_rvalid, LSU_rvalid, SRAM_rready}), 64'd0);
      @(negedge clk);
    end
    stale_rv = 1'b0;
    IFU_rready = 1'b0;
    LSU_rready = 1'b0;
    rd(1'b0, 32'h8000_0010, 0, l);
    chk("post_rst_ifu_lat", 64'(l), 64'd2);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
